// File: rtl/coffee_dispenser.sv
// Timed actuator sequencer for the coffee machine: cup drop, grind, brew,
// then optional milk and foam, driven by one-hot drink-select levels.
module coffee_dispenser #(
    parameter int T_CUP   = 4,
    parameter int T_GRIND = 8,
    parameter int T_BREW  = 16,
    parameter int T_MILK  = 10,
    parameter int T_FOAM  = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       expr,
    input  logic       latte,
    input  logic       capp,
    input  logic       abort,
    output logic       cup_drop,
    output logic       grind,
    output logic       brew,
    output logic       milk,
    output logic       foam,
    output logic       busy,
    output logic       done,
    output logic       aborted,
    output logic [1:0] recipe
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CUP   = 3'd1,
        S_GRIND = 3'd2,
        S_BREW  = 3'd3,
        S_MILK  = 3'd4,
        S_FOAM  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [1:0] RCP_NONE = 2'b00;
    localparam logic [1:0] RCP_ESPR = 2'b01;
    localparam logic [1:0] RCP_LATT = 2'b10;
    localparam logic [1:0] RCP_CAPP = 2'b11;

    state_t     state_r;
    state_t     state_nx_s;
    logic [7:0] cnt_r;
    logic [7:0] cnt_nx_s;
    logic [1:0] recipe_r;
    logic [1:0] recipe_nx_s;
    logic       sel_prev_r;
    logic       sel_s;
    logic       start_s;
    logic       abort_take_s;

    // Counter preload for a phase: the phase ends when the counter reads zero.
    function automatic logic [7:0] phase_load(input state_t s);
        case (s)
            S_CUP:   return 8'(T_CUP - 1);
            S_GRIND: return 8'(T_GRIND - 1);
            S_BREW:  return 8'(T_BREW - 1);
            S_MILK:  return 8'(T_MILK - 1);
            S_FOAM:  return 8'(T_FOAM - 1);
            default: return 8'd0;
        endcase
    endfunction

    assign sel_s   = expr | latte | capp;
    assign start_s = sel_s & ~sel_prev_r & (state_r == S_IDLE);

    // Next-state, counter and recipe selection.
    always_comb begin
        state_nx_s   = state_r;
        cnt_nx_s     = cnt_r;
        recipe_nx_s  = recipe_r;
        abort_take_s = 1'b0;
        case (state_r)
            S_IDLE: begin
                cnt_nx_s    = 8'd0;
                recipe_nx_s = RCP_NONE;
                if (start_s) begin
                    state_nx_s = S_CUP;
                    if (expr) begin
                        recipe_nx_s = RCP_ESPR;
                    end else if (latte) begin
                        recipe_nx_s = RCP_LATT;
                    end else begin
                        recipe_nx_s = RCP_CAPP;
                    end
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_CUP, S_GRIND, S_BREW, S_MILK, S_FOAM: begin
                if (abort) begin
                    state_nx_s   = S_IDLE;
                    recipe_nx_s  = RCP_NONE;
                    abort_take_s = 1'b1;
                end else if (cnt_r == 8'd0) begin
                    case (state_r)
                        S_CUP:   state_nx_s = S_GRIND;
                        S_GRIND: state_nx_s = S_BREW;
                        S_BREW:  state_nx_s = (recipe_r == RCP_ESPR) ? S_DONE : S_MILK;
                        S_MILK:  state_nx_s = (recipe_r == RCP_CAPP) ? S_FOAM : S_DONE;
                        default: state_nx_s = S_DONE;
                    endcase
                end else begin
                    cnt_nx_s = cnt_r - 8'd1;
                end
            end
            S_DONE: begin
                state_nx_s  = S_IDLE;
                recipe_nx_s = RCP_NONE;
            end
            default: begin
                state_nx_s  = S_IDLE;
                recipe_nx_s = RCP_NONE;
                cnt_nx_s    = 8'd0;
            end
        endcase
        // Any state change is a phase entry, so the counter is reloaded there.
        if (state_nx_s != state_r) begin
            cnt_nx_s = phase_load(state_nx_s);
        end else begin
            cnt_nx_s = cnt_nx_s;
        end
    end

    // State, counter, select history and recipe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_IDLE;
            cnt_r      <= 8'd0;
            sel_prev_r <= 1'b0;
            recipe_r   <= RCP_NONE;
        end else begin
            state_r    <= state_nx_s;
            cnt_r      <= cnt_nx_s;
            sel_prev_r <= sel_s;
            recipe_r   <= recipe_nx_s;
        end
    end

    // Registered outputs decoded from the state being entered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cup_drop <= 1'b0;
            grind    <= 1'b0;
            brew     <= 1'b0;
            milk     <= 1'b0;
            foam     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            aborted  <= 1'b0;
            recipe   <= RCP_NONE;
        end else begin
            cup_drop <= (state_nx_s == S_CUP);
            grind    <= (state_nx_s == S_GRIND);
            brew     <= (state_nx_s == S_BREW);
            milk     <= (state_nx_s == S_MILK);
            foam     <= (state_nx_s == S_FOAM);
            busy     <= (state_nx_s != S_IDLE);
            done     <= (state_nx_s == S_DONE);
            aborted  <= abort_take_s;
            recipe   <= recipe_nx_s;
        end
    end

endmodule

// File: tb/tb_coffee_dispenser.sv
// Directed self-checking bench for coffee_dispenser: default timing instance
// plus an all-ones timing instance for the short-phase corner.
module tb_coffee_dispenser;

    logic clk;
    logic rst_n;
    logic expr;
    logic latte;
    logic capp;
    logic abort;

    logic cup1, grd1, brw1, mlk1, fom1, bsy1, dn1, ab1;
    logic [1:0] rcp1;
    logic cup2, grd2, brw2, mlk2, fom2, bsy2, dn2, ab2;
    logic [1:0] rcp2;

    logic [9:0] vec1_s;
    logic [9:0] vec2_s;

    int checks_cnt;
    int fail_cnt;

    coffee_dispenser u_dut (
        .clk(clk), .rst_n(rst_n), .expr(expr), .latte(latte), .capp(capp), .abort(abort),
        .cup_drop(cup1), .grind(grd1), .brew(brw1), .milk(mlk1), .foam(fom1),
        .busy(bsy1), .done(dn1), .aborted(ab1), .recipe(rcp1)
    );

    coffee_dispenser #(
        .T_CUP(1), .T_GRIND(1), .T_BREW(1), .T_MILK(1), .T_FOAM(1)
    ) u_dut_min (
        .clk(clk), .rst_n(rst_n), .expr(expr), .latte(latte), .capp(capp), .abort(abort),
        .cup_drop(cup2), .grind(grd2), .brew(brw2), .milk(mlk2), .foam(fom2),
        .busy(bsy2), .done(dn2), .aborted(ab2), .recipe(rcp2)
    );

    // Output bundle order: cup, grind, brew, milk, foam, busy, done, aborted, recipe.
    assign vec1_s = {cup1, grd1, brw1, mlk1, fom1, bsy1, dn1, ab1, rcp1};
    assign vec2_s = {cup2, grd2, brw2, mlk2, fom2, bsy2, dn2, ab2, rcp2};

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [9:0] got, input logic [9:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected output bundle k cycles after the start edge.
    function automatic logic [9:0] exp_vec(input logic [1:0] rec, input int k,
                                           input int tc, input int tg, input int tb,
                                           input int tm, input int tf);
        int c, g, b, m, f;
        c = tc;
        g = c + tg;
        b = g + tb;
        m = b + ((rec == 2'b10 || rec == 2'b11) ? tm : 0);
        f = m + ((rec == 2'b11) ? tf : 0);
        if (k < c)       return {5'b10000, 3'b100, rec};
        else if (k < g)  return {5'b01000, 3'b100, rec};
        else if (k < b)  return {5'b00100, 3'b100, rec};
        else if (k < m)  return {5'b00010, 3'b100, rec};
        else if (k < f)  return {5'b00001, 3'b100, rec};
        else if (k == f) return {5'b00000, 3'b110, rec};
        else             return 10'b0;
    endfunction

    // Check cycles k_from..k_to-1 after the start edge, stepping after each.
    task automatic follow(input string tag, input bit short_inst, input logic [1:0] rec,
                          input int k_from, input int k_to);
        logic [9:0] e;
        for (int k = k_from; k < k_to; k++) begin
            if (short_inst) begin
                e = exp_vec(rec, k, 1, 1, 1, 1, 1);
                check_val($sformatf("%s_k%0d", tag, k), vec2_s, e);
            end else begin
                e = exp_vec(rec, k, 4, 8, 16, 10, 6);
                check_val($sformatf("%s_k%0d", tag, k), vec1_s, e);
            end
            step();
        end
    endtask

    initial begin
        checks_cnt = 0;
        fail_cnt   = 0;
        rst_n = 1'b0;
        expr  = 1'b0;
        latte = 1'b0;
        capp  = 1'b0;
        abort = 1'b0;
        #1;
        check_val("reset_main", vec1_s, 10'b0);
        check_val("reset_min", vec2_s, 10'b0);
        step();
        step();
        rst_n = 1'b1;
        step();
        check_val("idle_main", vec1_s, 10'b0);

        // Espresso from a single-cycle pulse.
        expr = 1'b1;
        step();
        expr = 1'b0;
        follow("esp", 1'b0, 2'b01, 0, 31);

        // Espresso and cappuccino together; espresso wins and holding it never retriggers.
        expr = 1'b1;
        capp = 1'b1;
        step();
        capp = 1'b0;
        follow("prio", 1'b0, 2'b01, 0, 60);
        expr = 1'b0;
        step();

        // Cappuccino twice, second start after select has been low.
        capp = 1'b1;
        step();
        capp = 1'b0;
        follow("cap1", 1'b0, 2'b11, 0, 46);
        capp = 1'b1;
        step();
        capp = 1'b0;
        follow("cap2", 1'b0, 2'b11, 0, 46);

        // Abort sampled at E20 in BREW, then a latte edge at E22.
        expr = 1'b1;
        step();
        expr = 1'b0;
        follow("abt_pre", 1'b0, 2'b01, 0, 20);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check_val("abt_e20", vec1_s, 10'b0000000100);
        step();
        check_val("abt_e21", vec1_s, 10'b0);
        latte = 1'b1;
        step();
        latte = 1'b0;
        follow("abt_latte", 1'b0, 2'b10, 0, 40);

        // Asynchronous reset during MILK, released with latte held high.
        latte = 1'b1;
        step();
        latte = 1'b0;
        follow("rst_pre", 1'b0, 2'b10, 0, 32);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("rst_async", vec1_s, 10'b0);
        latte = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        follow("rst_latte", 1'b0, 2'b10, 0, 45);
        latte = 1'b0;
        step();

        // All-ones timing instance, cappuccino, latte raised mid-sequence.
        rst_n = 1'b0;
        #1;
        check_val("min_reset", vec2_s, 10'b0);
        step();
        rst_n = 1'b1;
        step();
        capp = 1'b1;
        step();
        capp = 1'b0;
        follow("min_cap", 1'b1, 2'b11, 0, 2);
        latte = 1'b1;
        follow("min_cap", 1'b1, 2'b11, 2, 10);
        latte = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
